// File: rtl/stream_framer_if.sv
// Stream framer bus: raw input beats in, framed beats with
// string/frame markers and status out.
interface stream_framer_if #(
  parameter int DATA_WIDTH = 8
);
  // Raw input side
  logic                  data_valid_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  frame_start_i;

  // Framed output side
  logic [DATA_WIDTH-1:0] data_o;
  logic                  data_valid_o;
  logic                  sop_o;
  logic                  eop_o;
  logic                  sof_o;
  logic                  eof_o;
  logic                  busy_o;
  logic                  frame_err_o;

  // Framer side: consumes raw beats, produces framed beats
  modport slave (
    input  data_valid_i, data_i, frame_start_i,
    output data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, busy_o, frame_err_o
  );

  // Source/sink side: drives raw beats, observes framed beats
  modport master (
    output data_valid_i, data_i, frame_start_i,
    input  data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, busy_o, frame_err_o
  );
endinterface

// File: rtl/stream_framer.sv
// Stream framer: tags a raw beat stream with start/end-of-string and
// start/end-of-frame markers. A frame is STRING_NUM strings of
// STRING_LEN*CHANNEL_NUM beats each, beginning at a beat qualified with
// frame_start_i. All outputs are registered with one cycle of latency.
module stream_framer #(
  parameter int DATA_WIDTH  = 8,
  parameter int STRING_LEN  = 7,
  parameter int STRING_NUM  = 7,
  parameter int CHANNEL_NUM = 1
) (
  input  logic           clk,
  input  logic           reset,
  stream_framer_if.slave bus
);

  localparam int BPS   = STRING_LEN * CHANNEL_NUM;
  localparam int COL_W = (BPS > 1) ? $clog2(BPS) : 1;
  localparam int ROW_W = (STRING_NUM > 1) ? $clog2(STRING_NUM) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BPS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(STRING_NUM - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [COL_W-1:0]      col_reg, col_next;
  logic [ROW_W-1:0]      row_reg, row_next;

  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  valid_reg, valid_next;
  logic                  sop_reg, sop_next;
  logic                  eop_reg, eop_next;
  logic                  sof_reg, sof_next;
  logic                  eof_reg, eof_next;
  logic                  busy_reg, busy_next;
  logic                  err_reg, err_next;

  // Beat classification helpers
  logic                  start;
  logic                  emit;
  logic [COL_W-1:0]      cur_col;
  logic [ROW_W-1:0]      cur_row;
  logic                  at_eop;
  logic                  at_eof;

  // Next-state, counter and output decode for the beat presented this cycle
  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    sop_next   = 1'b0;
    eop_next   = 1'b0;
    sof_next   = 1'b0;
    eof_next   = 1'b0;
    err_next   = 1'b0;

    // frame_start_i only counts when the beat itself is valid
    start = bus.data_valid_i && bus.frame_start_i;
    // In IDLE only a frame start is emitted; stray beats are dropped
    emit  = bus.data_valid_i && (bus.frame_start_i || (state_reg == ACTIVE));

    // A frame start always occupies position (0,0), even mid-frame
    cur_col = start ? '0 : col_reg;
    cur_row = start ? '0 : row_reg;
    at_eop  = (cur_col == COL_LAST);
    at_eof  = at_eop && (cur_row == ROW_LAST);

    if (emit) begin
      data_next  = bus.data_i;
      valid_next = 1'b1;
      sop_next   = (cur_col == '0);
      eop_next   = at_eop;
      sof_next   = start;
      eof_next   = at_eof;
      // Restarting while a frame is open abandons that frame
      err_next   = start && (state_reg == ACTIVE);

      if (at_eof) begin
        // Also covers the single-beat frame, which never leaves IDLE
        state_next = IDLE;
        col_next   = '0;
        row_next   = '0;
      end else if (at_eop) begin
        state_next = ACTIVE;
        col_next   = '0;
        row_next   = cur_row + ROW_W'(1);
      end else begin
        state_next = ACTIVE;
        col_next   = cur_col + COL_W'(1);
        row_next   = cur_row;
      end
    end

    busy_next = (state_next == ACTIVE);
  end

  // State, counters and registered outputs; reset drops any partial frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      col_reg   <= '0;
      row_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      sop_reg   <= 1'b0;
      eop_reg   <= 1'b0;
      sof_reg   <= 1'b0;
      eof_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      sop_reg   <= sop_next;
      eop_reg   <= eop_next;
      sof_reg   <= sof_next;
      eof_reg   <= eof_next;
      busy_reg  <= busy_next;
      err_reg   <= err_next;
    end
  end

  assign bus.data_o       = data_reg;
  assign bus.data_valid_o = valid_reg;
  assign bus.sop_o        = sop_reg;
  assign bus.eop_o        = eop_reg;
  assign bus.sof_o        = sof_reg;
  assign bus.eof_o        = eof_reg;
  assign bus.busy_o       = busy_reg;
  assign bus.frame_err_o  = err_reg;

endmodule

// File: doc/stream_framer.md
STREAM_FRAMER -- requirements
Module: stream_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel data width in bits.
REQ-002 Parameter STRING_LEN, default 7, pixel positions per string (line).
REQ-003 Parameter STRING_NUM, default 7, strings per frame.
REQ-004 Parameter CHANNEL_NUM, default 1, beats per pixel position; beats per string BPS = STRING_LEN*CHANNEL_NUM.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 data_valid_i  input  1  input beat qualifier.
REQ-008 data_i  input  DATA_WIDTH  raw pixel/channel data, sampled when data_valid_i=1.
REQ-009 frame_start_i  input  1  marks the current beat as first of a frame; meaningful only with data_valid_i=1.
REQ-010 data_o  output  DATA_WIDTH  framed data.
REQ-011 data_valid_o  output  1  output beat qualifier.
REQ-012 sop_o  output  1  first beat of a string.
REQ-013 eop_o  output  1  last beat of a string.
REQ-014 sof_o  output  1  first beat of a frame.
REQ-015 eof_o  output  1  last beat of a frame.
REQ-016 busy_o  output  1  high while state is ACTIVE.
REQ-017 frame_err_o  output  1  one-cycle pulse on aborted frame.

Function
REQ-018 All outputs SHALL be registered; accepted beat appears on outputs exactly 1 cycle after sampling.
REQ-019 States: IDLE, ACTIVE; column counter col (0..BPS-1), row counter row (0..STRING_NUM-1), widths $clog2 of range, minimum 1 bit.
REQ-020 IDLE: beats with data_valid_i=1, frame_start_i=0 SHALL be discarded (data_valid_o=0, no flags).
REQ-021 IDLE, data_valid_i=1 & frame_start_i=1: emit beat with sof_o=1, sop_o=1; col=1, row=0; go ACTIVE (unless REQ-026 applies).
REQ-022 ACTIVE, data_valid_i=1 & frame_start_i=0: emit beat; sop_o=1 when col=0; eop_o=1 when col=BPS-1; col wraps to 0 and row increments on eop.
REQ-023 Beat with col=BPS-1 and row=STRING_NUM-1 SHALL carry eof_o=1 and eop_o=1; state returns to IDLE, counters cleared.
REQ-024 ACTIVE, data_valid_i=1 & frame_start_i=1: current frame aborted (no eof emitted for it); frame_err_o=1 for one cycle coincident with the output beat; beat emitted as sof_o=1, sop_o=1 of a new frame; counters restart per REQ-021.
REQ-025 frame_start_i with data_valid_i=0 SHALL be ignored in every state; data_valid_i=0 cycles SHALL not advance counters (gaps allowed anywhere).
REQ-026 Degenerate sizes: BPS=1 gives sop_o=eop_o=1 every beat; STRING_NUM=1 gives sof_o and eof_o in the same string; BPS=1 and STRING_NUM=1 gives all four flags on one beat and state stays IDLE.
REQ-027 sop_o, eop_o, sof_o, eof_o SHALL be 0 whenever data_valid_o=0.
REQ-028 data_o SHALL update only on emitted beats and hold its value otherwise.
REQ-029 busy_o SHALL reflect the registered state (1 in ACTIVE), updating the cycle after the transition.

Reset
REQ-030 While reset=1: data_o=0, data_valid_o=0, sop_o=eop_o=sof_o=eof_o=0, busy_o=0, frame_err_o=0, state IDLE, col=row=0.
REQ-031 Reset asserted mid-frame SHALL drop the partial frame without eof_o or frame_err_o; after release, beats discarded until next frame_start_i.

Verification
REQ-032 STRING_LEN=4, CHANNEL_NUM=2, STRING_NUM=3, 24 contiguous beats data 0..23 with frame_start_i on beat 0 -> outputs 0..23 at 1-cycle latency; sop on 0,8,16; eop on 7,15,23; sof on 0; eof on 23; busy_o falls after beat 23.
REQ-033 Same frame with data_valid_i toggling 1,0 -> identical flag positions per beat, gaps carry data_valid_o=0 and no flags.
REQ-034 5 valid beats without frame_start_i in IDLE, then a frame -> no output for the 5 beats; frame framed correctly.
REQ-035 frame_start_i at beat 10 of a frame -> frame_err_o=1 with that beat, sof_o=1, sop_o=1; next 23 beats end with eof_o.
REQ-036 reset pulse at beat 12 -> all outputs 0 next cycle; following frame starting with frame_start_i framed correctly, no frame_err_o.
REQ-037 STRING_LEN=1, CHANNEL_NUM=1, STRING_NUM=1, single beat with frame_start_i -> sop_o=eop_o=sof_o=eof_o=1, busy_o stays 0.
